// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-enabled data memory with synchronous write, combinational read and store trace
module data_mem #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  DMWOp,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic [3:0]  byteen,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        align_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_SW   = 2'd1;
  localparam logic [1:0] OP_SH   = 2'd2;
  localparam logic [1:0] OP_SB   = 2'd3;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            raw_en;
  logic [31:0]           lanes;
  logic [31:0]           merged;
  logic                  store;
  logic                  misalign;
  logic                  out_of_range;
  logic                  illegal;
  logic                  commit;

  assign idx          = addr[DEPTH_LOG2+1:2];
  assign rdata        = mem[idx];
  assign store        = (DMWOp != OP_NONE);
  assign out_of_range = |(addr >> (DEPTH_LOG2 + 2));
  assign illegal      = store && (misalign || out_of_range);
  assign commit       = store && !illegal;

  always_comb begin
    raw_en   = 4'b0000;
    lanes    = wdata;
    misalign = 1'b0;
    case (DMWOp)
      OP_SW: begin
        raw_en   = 4'b1111;
        misalign = (addr[1:0] != 2'b00);
      end
      OP_SH: begin
        raw_en   = addr[1] ? 4'b1100 : 4'b0011;
        lanes    = {2{wdata[15:0]}};
        misalign = addr[0];
      end
      OP_SB: begin
        raw_en = 4'b0001 << addr[1:0];
        lanes  = {4{wdata[7:0]}};
      end
      default: begin
        raw_en = 4'b0000;
      end
    endcase
  end

  // Suppressed stores present no enables, so the merge below leaves the word intact.
  always_comb begin
    byteen = illegal ? 4'b0000 : raw_en;
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[8*i +: 8] = lanes[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      trace_valid <= 1'b0;
      trace_pc    <= 32'h0;
      trace_addr  <= 32'h0;
      trace_data  <= 32'h0;
      align_err   <= 1'b0;
    end else begin
      trace_valid <= commit;
      align_err   <= illegal;
      if (commit) begin
        mem[idx]   <= merged;
        trace_pc   <= pc;
        trace_addr <= {addr[31:2], 2'b00};
        trace_data <= merged;
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed scoreboard bench for data_mem
module tb_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  DMWOp;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic [3:0]  byteen;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        align_err;

  data_mem #(.DEPTH_LOG2(12)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .DMWOp(DMWOp), .pc(pc),
    .rdata(rdata), .byteen(byteen), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } trace_t;

  trace_t      sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] last_pc = 0, last_addr = 0, last_data = 0;

  function automatic trace_t tr_ok(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
    trace_t t;
    t.valid = 1'b1; t.pc = p; t.addr = a; t.data = d; t.err = 1'b0;
    return t;
  endfunction

  function automatic trace_t tr_quiet(input logic err);
    trace_t t;
    t.valid = 1'b0; t.pc = 32'h0; t.addr = 32'h0; t.data = 32'h0; t.err = err;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_trace(input string tag);
    trace_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'h1, 32'h0);
      return;
    end
    e = sb.pop_front();
    check({tag, " trace_valid"}, {31'h0, trace_valid}, {31'h0, e.valid});
    check({tag, " align_err"}, {31'h0, align_err}, {31'h0, e.err});
    if (e.valid) begin
      last_pc = e.pc; last_addr = e.addr; last_data = e.data;
    end
    check({tag, " trace_pc"}, trace_pc, last_pc);
    check({tag, " trace_addr"}, trace_addr, last_addr);
    check({tag, " trace_data"}, trace_data, last_data);
  endtask

  // Presents one M-stage op for a cycle; rdata is checked before the edge to see the old word.
  task automatic step(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] p, input logic [3:0] exp_be,
                      input logic [31:0] exp_old, input trace_t e);
    DMWOp = op; addr = a; wdata = d; pc = p;
    #1;
    check({tag, " byteen"}, {28'h0, byteen}, {28'h0, exp_be});
    check({tag, " rdata before edge"}, rdata, exp_old);
    sb.push_back(e);
    @(posedge clk);
    #1;
    DMWOp = 2'd0;
    check_trace(tag);
  endtask

  task automatic read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    DMWOp = 2'd0; addr = a;
    #1;
    check({tag, " rdata"}, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; DMWOp = 2'd0; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset trace_valid", {31'h0, trace_valid}, 32'h0);
    check("reset align_err", {31'h0, align_err}, 32'h0);
    check("reset trace_pc", trace_pc, 32'h0);
    check("reset trace_addr", trace_addr, 32'h0);
    check("reset trace_data", trace_data, 32'h0);
    read("reset word0", 32'h0000, 32'h0);
    read("reset word10", 32'h0010, 32'h0);
    read("reset top", 32'h3FFC, 32'h0);

    step("sw 0x10", 2'd1, 32'h10, 32'h11223344, 32'h3000, 4'b1111, 32'h0,
         tr_ok(32'h3000, 32'h10, 32'h11223344));
    read("after sw 0x10", 32'h10, 32'h11223344);

    step("sb 0x12", 2'd3, 32'h12, 32'hFFFFFFAB, 32'h3004, 4'b0100, 32'h11223344,
         tr_ok(32'h3004, 32'h10, 32'h11AB3344));
    read("after sb 0x12", 32'h10, 32'h11AB3344);

    step("sh 0x16", 2'd2, 32'h16, 32'h0000BEEF, 32'h3008, 4'b1100, 32'h0,
         tr_ok(32'h3008, 32'h14, 32'hBEEF0000));
    step("sb 0x14", 2'd3, 32'h14, 32'h0000005A, 32'h300C, 4'b0001, 32'hBEEF0000,
         tr_ok(32'h300C, 32'h14, 32'hBEEF005A));
    step("sb 0x15", 2'd3, 32'h15, 32'h12345677, 32'h3010, 4'b0010, 32'hBEEF005A,
         tr_ok(32'h3010, 32'h14, 32'hBEEF775A));
    step("sb 0x17", 2'd3, 32'h17, 32'h00000001, 32'h3014, 4'b1000, 32'hBEEF775A,
         tr_ok(32'h3014, 32'h14, 32'h01EF775A));
    step("sh 0x14", 2'd2, 32'h14, 32'hFFFF1234, 32'h3018, 4'b0011, 32'h01EF775A,
         tr_ok(32'h3018, 32'h14, 32'h01EF1234));
    read("after halves", 32'h14, 32'h01EF1234);

    step("sw 0x21", 2'd1, 32'h21, 32'hDEADBEEF, 32'h3020, 4'b0000, 32'h0, tr_quiet(1'b1));
    step("sh 0x23", 2'd2, 32'h23, 32'hDEADBEEF, 32'h3024, 4'b0000, 32'h0, tr_quiet(1'b1));
    read("after misaligned", 32'h20, 32'h0);
    step("idle after err", 2'd0, 32'h20, 32'h0, 32'h3028, 4'b0000, 32'h0, tr_quiet(1'b0));
    step("sb 0x21", 2'd3, 32'h21, 32'h000000C3, 32'h302C, 4'b0010, 32'h0,
         tr_ok(32'h302C, 32'h20, 32'h0000C300));

    step("sw 0x4000", 2'd1, 32'h4000, 32'hDEADBEEF, 32'h3030, 4'b0000, 32'h0, tr_quiet(1'b1));
    step("sb high addr", 2'd3, 32'h80000010, 32'h000000EE, 32'h3034, 4'b0000, 32'h11AB3344,
         tr_quiet(1'b1));
    read("word0 after oob", 32'h0, 32'h0);
    read("word10 after oob", 32'h10, 32'h11AB3344);

    step("none oob", 2'd0, 32'hFFFF0010, 32'h99999999, 32'h3038, 4'b0000, 32'h11AB3344,
         tr_quiet(1'b0));
    step("none 0x10", 2'd0, 32'h10, 32'h99999999, 32'h303C, 4'b0000, 32'h11AB3344,
         tr_quiet(1'b0));
    read("word10 after none", 32'h10, 32'h11AB3344);

    step("sw top", 2'd1, 32'h3FFC, 32'hA5A5A5A5, 32'h3040, 4'b1111, 32'h0,
         tr_ok(32'h3040, 32'h3FFC, 32'hA5A5A5A5));
    read("top word", 32'h3FFC, 32'hA5A5A5A5);

    step("sw 0x40", 2'd1, 32'h40, 32'hCAFEBABE, 32'h3044, 4'b1111, 32'h0,
         tr_ok(32'h3044, 32'h40, 32'hCAFEBABE));
    read("word40", 32'h40, 32'hCAFEBABE);

    reset = 1'b1; DMWOp = 2'd1; addr = 32'h44; wdata = 32'h55555555; pc = 32'h3048;
    @(posedge clk);
    #1;
    reset = 1'b0; DMWOp = 2'd0;
    last_pc = 32'h0; last_addr = 32'h0; last_data = 32'h0;
    check("rst+sw trace_valid", {31'h0, trace_valid}, 32'h0);
    check("rst+sw align_err", {31'h0, align_err}, 32'h0);
    check("rst+sw trace_data", trace_data, 32'h0);
    check("rst+sw trace_pc", trace_pc, 32'h0);
    read("rst word40", 32'h40, 32'h0);
    read("rst word44", 32'h44, 32'h0);
    read("rst word10", 32'h10, 32'h0);
    read("rst top", 32'h3FFC, 32'h0);

    step("idle after rst", 2'd0, 32'h44, 32'h0, 32'h0, 4'b0000, 32'h0, tr_quiet(1'b0));
    check("scoreboard drained", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the word count (4096 words, 16 KiB, byte addresses 0x0000-0x3FFF).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port addr, input, 32 bits: byte address from the M-stage ALU result.
REQ-005 SHALL have port wdata, input, 32 bits: store source register value, with the payload in the low bits.
REQ-006 SHALL have port DMWOp, input, 2 bits: 0 = none, 1 = sw, 2 = sh, 3 = sb.
REQ-007 SHALL have port pc, input, 32 bits: PC of the M-stage instruction, used for trace only.
REQ-008 SHALL have port rdata, output, 32 bits: raw aligned word, consumed by the load-extension stage together with addr[1:0].
REQ-009 SHALL have port byteen, output, 4 bits: byte enables applied this cycle.
REQ-010 SHALL have port trace_valid, output, 1 bit: a committed write occurred on the previous edge.
REQ-011 SHALL have ports trace_pc, trace_addr and trace_data, output, 32 bits each: the store's PC, its word-aligned address, and the full merged word after the write.
REQ-012 SHALL have port align_err, output, 1 bit: the previous-cycle store was misaligned or out of range and was suppressed.

Function
REQ-013 SHALL read combinationally: rdata = mem[addr[DEPTH_LOG2+1:2]], always a full word regardless of DMWOp.
REQ-014 SHALL generate byteen combinationally as follows:
- sw: 4'b1111.
- sh: 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
- sb: 4'b0001 shifted left by addr[1:0].
- none: 4'b0000.
REQ-015 SHALL position the store data on the lanes: sb replicates wdata[7:0] to all four lanes, sh replicates wdata[15:0] to both halves, sw passes wdata unchanged.
REQ-016 SHALL, on a rising edge with reset=0 and a legal store, write only the enabled byte lanes of the addressed word; disabled lanes keep their value.
REQ-017 SHALL treat a store as illegal in any of these cases, and the word SHALL then be unchanged and byteen forced to 4'b0000:
- sw with addr[1:0]≠0.
- sh with addr[0]=1.
- any store with addr[31:DEPTH_LOG2+2]≠0.
REQ-018 SHALL register trace_valid=1 one cycle after each legal store, with trace_pc=pc, trace_addr={addr[31:2],2'b00}, and trace_data equal to the merged word; otherwise trace_valid=0 and the other trace fields hold their last value.
REQ-019 SHALL register align_err=1 for exactly one cycle after each illegal store; a legal store or no store gives 0.
REQ-020 SHALL, when a read and a store target the same word in the same cycle, return the old word on rdata that cycle and the merged word from the next cycle.
REQ-021 SHALL complete back-to-back stores to the same word on consecutive edges, each merging onto the result of the previous one.
REQ-022 SHALL produce no write and no trace when DMWOp=0, whatever the address, including out-of-range addresses.
REQ-023 SHALL keep the write latency at one edge and the read latency at zero cycles, with no stall or handshake.

Reset
REQ-024 SHALL, on a rising edge with reset=1, clear every memory word to 0 and set trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0 and align_err=0.
REQ-025 SHALL give reset priority over a store presented in the same cycle: the store is discarded and no trace is produced.
REQ-026 SHALL hold the cleared state until the first edge with reset=0; rdata after reset reads 0 at every address.

Verification
REQ-027 SHALL pass this scenario: reset, then sw addr=0x10 wdata=0x11223344 at pc=0x3000 -> next cycle trace_valid=1, trace_addr=0x10, trace_data=0x11223344, trace_pc=0x3000, and rdata at 0x10 = 0x11223344.
REQ-028 SHALL pass this scenario: after REQ-027, sb addr=0x12 wdata=0xFFFFFFAB -> byteen=0100, and the word becomes 0x11AB3344.
REQ-029 SHALL pass this scenario: sh addr=0x16 wdata=0x0000BEEF on a zero word -> byteen=1100, and the word becomes 0xBEEF0000.
REQ-030 SHALL pass this scenario: sw addr=0x21 and sh addr=0x23 -> align_err=1 on each following cycle, trace_valid=0, and the memory is unchanged.
REQ-031 SHALL pass this scenario: sw addr=0x4000 -> align_err=1, and word 0 is unchanged.
REQ-032 SHALL pass this scenario: write 0xCAFEBABE to 0x40, then assert reset for one cycle together with sw addr=0x44 -> afterwards reads at 0x40 and 0x44 are 0, and trace_valid=0.
